// File: rtl/aos_sr_router_nway.sv
// Purpose: single-level N-way soft-register router, host SoftReg port to NUM_APPS app ports.
// Latency: host req -> app req 2 cycles (empty FIFO, IDLE); app resp -> host resp 1 cycle.
// Backpressure: none upstream; requests arriving on a full ingress FIFO are dropped and counted.
// Ports: clk/rst_n; app_enable per-app gate; softreg_req/softreg_resp host side;
//        app_softreg_req/app_softreg_resp per-app side; busy = read outstanding;
//        drop_count/timeout_count/stray_count saturating diagnostics.

package aos_sr_router_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;
endpackage

// Purpose: generic show-ahead FIFO, head visible on dout whenever !empty.
// Latency: push visible at head the cycle after the write.
// Backpressure: push ignored when full, pop ignored when empty.
module aos_sr_fifo #(
    parameter int DW        = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [DW-1:0]        mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module aos_sr_router_nway
    import aos_sr_router_pkg::*;
#(
    parameter int          NUM_APPS           = 4,
    parameter int          SEL_LSB            = 3,
    parameter int          REQ_FIFO_LOG_DEPTH = 2,
    parameter int          TIMEOUT_CYCLES     = 1024,
    parameter logic [63:0] ERR_DATA           = 64'hDEAD_DEAD_DEAD_DEAD,
    parameter int          CNT_W              = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_APPS-1:0] app_enable,
    input  SoftRegReq           softreg_req,
    output SoftRegResp          softreg_resp,
    output SoftRegReq           app_softreg_req [NUM_APPS],
    input  SoftRegResp          app_softreg_resp [NUM_APPS],
    output logic                busy,
    output logic [CNT_W-1:0]    drop_count,
    output logic [CNT_W-1:0]    timeout_count,
    output logic [CNT_W-1:0]    stray_count
);
    localparam int SEL_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0]      SEL_MASK = ((64'd1 << SEL_W) - 64'd1) << SEL_LSB;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Ingress FIFO
    SoftRegReq head;
    logic      fifo_full, fifo_empty, pop;

    aos_sr_fifo #(
        .DW        ($bits(SoftRegReq)),
        .LOG_DEPTH (REQ_FIFO_LOG_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (softreg_req.valid),
        .din   (softreg_req),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode. An index >= NUM_APPS matches no loop iteration, so head_legal
    // covers both the range check and the enable check.
    logic [SEL_W-1:0] head_idx;
    logic             head_legal;
    SoftRegReq        fwd_req;

    assign head_idx = head.addr[SEL_LSB +: SEL_W];

    always_comb begin
        head_legal = 1'b0;
        for (int j = 0; j < NUM_APPS; j++) begin
            if (head_idx == SEL_W'(j)) head_legal = app_enable[j];
        end
        fwd_req       = head;
        fwd_req.valid = 1'b1;
        fwd_req.addr  = head.addr & ~SEL_MASK;
    end

    // Awaited-response mux and stray detection
    SoftRegResp          awaited;
    logic [NUM_APPS-1:0] stray_vec;
    logic [CNT_W-1:0]    stray_inc;

    always_comb begin
        awaited   = '0;
        stray_vec = '0;
        stray_inc = '0;
        for (int j = 0; j < NUM_APPS; j++) begin
            if (idx_q == SEL_W'(j)) awaited = app_softreg_resp[j];
            stray_vec[j] = app_softreg_resp[j].valid &&
                           !(state_q == ST_WAIT && idx_q == SEL_W'(j));
            stray_inc = stray_inc + CNT_W'(stray_vec[j]);
        end
    end

    // FSM next state / outputs
    logic       fire;
    logic       drop_dec;
    logic       tmo;
    SoftRegResp resp_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        fire     = 1'b0;
        drop_dec = 1'b0;
        tmo      = 1'b0;
        resp_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        fire = 1'b1;
                        if (!head.isWrite) begin
                            state_d = ST_WAIT;
                            idx_d   = head_idx;
                            timer_d = '0;
                        end
                    end else begin
                        drop_dec = 1'b1;
                        if (!head.isWrite) begin
                            resp_d.valid = 1'b1;
                            resp_d.data  = ERR_DATA;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // A response arriving on the last timer cycle still wins.
                if (awaited.valid) begin
                    resp_d.valid = 1'b1;
                    resp_d.data  = awaited.data;
                    state_d      = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    resp_d.valid = 1'b1;
                    resp_d.data  = ERR_DATA;
                    tmo          = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [CNT_W-1:0] drop_inc;
    assign drop_inc = CNT_W'(softreg_req.valid && fifo_full) + CNT_W'(drop_dec);
    assign busy     = (state_q == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            softreg_resp  <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
            stray_count   <= '0;
            for (int j = 0; j < NUM_APPS; j++) app_softreg_req[j] <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            softreg_resp  <= resp_d;
            drop_count    <= sat_add(drop_count, drop_inc);
            timeout_count <= sat_add(timeout_count, CNT_W'(tmo));
            stray_count   <= sat_add(stray_count, stray_inc);
            for (int j = 0; j < NUM_APPS; j++) begin
                app_softreg_req[j] <= (fire && head_idx == SEL_W'(j)) ? fwd_req : '0;
            end
        end
    end
endmodule

// File: tb/tb_aos_sr_router_nway.sv
// Purpose: self-checking bench for aos_sr_router_nway (NUM_APPS=4, TIMEOUT_CYCLES=16, CNT_W=4).
// Latency: expected outputs carry their expected cycle; -1 means order-only.
// Backpressure: exercises ingress overflow while a read is outstanding.
module tb_aos_sr_router_nway;
    import aos_sr_router_pkg::*;

    localparam int          N   = 4;
    localparam int          TMO = 16;
    localparam int          CW  = 4;
    localparam logic [63:0] ERR = 64'hDEAD_DEAD_DEAD_DEAD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    app_enable;
    SoftRegReq       softreg_req;
    SoftRegResp      softreg_resp;
    SoftRegReq       app_softreg_req [N];
    SoftRegResp      app_softreg_resp [N];
    logic            busy;
    logic [CW-1:0]   drop_count, timeout_count, stray_count;

    aos_sr_router_nway #(
        .NUM_APPS           (N),
        .SEL_LSB            (3),
        .REQ_FIFO_LOG_DEPTH (2),
        .TIMEOUT_CYCLES     (TMO),
        .ERR_DATA           (ERR),
        .CNT_W              (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .app_enable       (app_enable),
        .softreg_req      (softreg_req),
        .softreg_resp     (softreg_resp),
        .app_softreg_req  (app_softreg_req),
        .app_softreg_resp (app_softreg_resp),
        .busy             (busy),
        .drop_count       (drop_count),
        .timeout_count    (timeout_count),
        .stray_count      (stray_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          app;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } app_exp_t;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } resp_exp_t;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [N-1:0] en;
        int          exp_app;
        logic [63:0] exp_addr;
    } vec_t;

    app_exp_t  app_q[$];
    resp_exp_t resp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [63:0] addr, input logic [63:0] data);
        softreg_req.valid   = 1'b1;
        softreg_req.isWrite = wr;
        softreg_req.addr    = addr;
        softreg_req.data    = data;
        step();
        softreg_req = '0;
    endtask

    task automatic exp_app(input int app, input logic wr, input logic [63:0] addr,
                           input logic [63:0] data, input int c);
        app_exp_t e;
        e.app = app; e.wr = wr; e.addr = addr; e.data = data; e.cyc = c;
        app_q.push_back(e);
    endtask

    task automatic exp_resp(input logic [63:0] data, input int c);
        resp_exp_t r;
        r.data = data; r.cyc = c;
        resp_q.push_back(r);
    endtask

    task automatic clear_resp();
        for (int j = 0; j < N; j++) app_softreg_resp[j] = '0;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        app_exp_t  e;
        resp_exp_t r;
        for (int j = 0; j < N; j++) begin
            if (app_softreg_req[j].valid) begin
                if (app_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL app_unexpected: app%0d got addr %h, required no request (cycle %0d)",
                             j, app_softreg_req[j].addr, cyc);
                end else begin
                    e = app_q.pop_front();
                    chk("app_idx",  64'(j), 64'(e.app));
                    chk("app_wr",   64'(app_softreg_req[j].isWrite), 64'(e.wr));
                    chk("app_addr", app_softreg_req[j].addr, e.addr);
                    chk("app_data", app_softreg_req[j].data, e.data);
                    if (e.cyc >= 0) chk("app_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
        end
        if (softreg_resp.valid) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got data %h, required no response (cycle %0d)",
                         softreg_resp.data, cyc);
            end else begin
                r = resp_q.pop_front();
                chk("resp_data", softreg_resp.data, r.data);
                if (r.cyc >= 0) chk("resp_cyc", 64'(cyc), 64'(r.cyc));
            end
        end
    end

    vec_t vecs [7];
    int   c;
    int   nb;
    int   drop_exp;

    initial begin
        vecs[0] = '{1'b1, 64'h18,                  64'h55,                  4'b1111,  3, 64'h0};
        vecs[1] = '{1'b1, 64'h1234_0013,           64'hA5A5,                4'b1111,  2, 64'h1234_0003};
        vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 4'b1111,  3, 64'hFFFF_FFFF_FFFF_FFE7};
        vecs[3] = '{1'b1, 64'h08,                  64'h99,                  4'b1101, -1, 64'h0};
        vecs[4] = '{1'b0, 64'h08,                  64'h0,                   4'b1101, -1, 64'h0};
        vecs[5] = '{1'b0, 64'h20,                  64'h0,                   4'b1110, -1, 64'h0};
        vecs[6] = '{1'b1, 64'h27,                  64'h1,                   4'b0001,  0, 64'h27};

        softreg_req = '0;
        app_enable  = '1;
        clear_resp();
        drop_exp = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_resp_vld",  64'(softreg_resp.valid), 64'h0);
        chk("rst_resp_data", softreg_resp.data, 64'h0);
        chk("rst_busy",      64'(busy), 64'h0);
        chk("rst_drop",      64'(drop_count), 64'h0);
        chk("rst_timeout",   64'(timeout_count), 64'h0);
        chk("rst_stray",     64'(stray_count), 64'h0);
        for (int j = 0; j < N; j++) begin
            chk("rst_app_ctl",  64'({app_softreg_req[j].valid, app_softreg_req[j].isWrite}), 64'h0);
            chk("rst_app_addr", app_softreg_req[j].addr, 64'h0);
            chk("rst_app_data", app_softreg_req[j].data, 64'h0);
        end
        rst_n = 1'b1;
        repeat (2) step();

        // Table-driven single requests
        for (int i = 0; i < 7; i++) begin
            app_enable = vecs[i].en;
            c = cyc;
            if (vecs[i].exp_app >= 0) begin
                exp_app(vecs[i].exp_app, vecs[i].wr, vecs[i].exp_addr, vecs[i].data, c + 2);
            end else begin
                drop_exp++;
                if (!vecs[i].wr) exp_resp(ERR, c + 2);
            end
            send(vecs[i].wr, vecs[i].addr, vecs[i].data);
            repeat (4) step();
            chk("vec_drop",    64'(drop_count), 64'(drop_exp));
            chk("vec_app_q",   64'(app_q.size()), 64'h0);
            chk("vec_resp_q",  64'(resp_q.size()), 64'h0);
        end
        app_enable = '1;

        // Read to app1, response five cycles after the request reaches it
        c = cyc;
        exp_app(1, 1'b0, 64'h0, 64'h77, c + 2);
        exp_resp(64'h1234, c + 8);
        send(1'b0, 64'h08, 64'h77);
        nb = 0;
        for (int i = 1; i <= 10; i++) begin
            if (busy) nb++;
            if (i == 7) begin
                app_softreg_resp[1].valid = 1'b1;
                app_softreg_resp[1].data  = 64'h1234;
            end else begin
                clear_resp();
            end
            step();
        end
        clear_resp();
        chk("rd_busy_cycles", 64'(nb), 64'd6);
        chk("rd_stray",       64'(stray_count), 64'h0);

        // Timeout on silent app2, then a late stray response
        c = cyc;
        exp_app(2, 1'b0, 64'h0, 64'h0, c + 2);
        exp_resp(ERR, c + 18);
        send(1'b0, 64'h10, 64'h0);
        nb = 0;
        for (int i = 1; i <= 24; i++) begin
            if (busy) nb++;
            if (i == 20) begin
                app_softreg_resp[2].valid = 1'b1;
                app_softreg_resp[2].data  = 64'hBAD;
            end else begin
                clear_resp();
            end
            step();
        end
        clear_resp();
        chk("tmo_busy_cycles", 64'(nb), 64'd16);
        chk("tmo_count",       64'(timeout_count), 64'd1);
        chk("tmo_stray",       64'(stray_count), 64'd1);

        // Response on the very cycle the timer expires: response wins
        c = cyc;
        exp_app(1, 1'b0, 64'h0, 64'h0, c + 2);
        exp_resp(64'hCAFE, c + 18);
        send(1'b0, 64'h08, 64'h0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 17) begin
                app_softreg_resp[1].valid = 1'b1;
                app_softreg_resp[1].data  = 64'hCAFE;
            end else begin
                clear_resp();
            end
            step();
        end
        clear_resp();
        chk("race_tmo_count", 64'(timeout_count), 64'd1);
        chk("race_stray",     64'(stray_count), 64'd1);

        // Six back-to-back writes while waiting: four queued, two dropped
        c = cyc;
        exp_app(0, 1'b0, 64'h0, 64'h0, c + 2);
        send(1'b0, 64'h00, 64'h0);
        repeat (2) step();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_app(3, 1'b1, 64'(k) << 8, 64'h100 + 64'(k), -1);
            else       drop_exp++;
            send(1'b1, 64'h18 | (64'(k) << 8), 64'h100 + 64'(k));
        end
        step();
        exp_resp(64'h5A, cyc + 1);
        app_softreg_resp[0].valid = 1'b1;
        app_softreg_resp[0].data  = 64'h5A;
        step();
        clear_resp();
        repeat (8) step();
        chk("ovf_drop",   64'(drop_count), 64'(drop_exp));
        chk("ovf_app_q",  64'(app_q.size()), 64'h0);
        chk("ovf_resp_q", 64'(resp_q.size()), 64'h0);

        // Reset pulse during WAIT: outstanding read is lost silently
        c = cyc;
        exp_app(2, 1'b0, 64'h0, 64'h0, c + 2);
        send(1'b0, 64'h10, 64'h0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drop_exp = 0;
        chk("mid_rst_busy",    64'(busy), 64'h0);
        chk("mid_rst_drop",    64'(drop_count), 64'h0);
        chk("mid_rst_timeout", 64'(timeout_count), 64'h0);
        chk("mid_rst_stray",   64'(stray_count), 64'h0);
        repeat (2) step();
        c = cyc;
        exp_app(1, 1'b0, 64'h0, 64'h0, c + 2);
        exp_resp(64'h4321, c + 5);
        send(1'b0, 64'h08, 64'h0);
        repeat (3) step();
        app_softreg_resp[1].valid = 1'b1;
        app_softreg_resp[1].data  = 64'h4321;
        step();
        clear_resp();
        repeat (3) step();
        chk("post_rst_app_q",  64'(app_q.size()), 64'h0);
        chk("post_rst_resp_q", 64'(resp_q.size()), 64'h0);

        // Stray popcount and counter saturation
        app_softreg_resp[0].valid = 1'b1;
        app_softreg_resp[1].valid = 1'b1;
        app_softreg_resp[3].valid = 1'b1;
        step();
        clear_resp();
        step();
        chk("stray_popcount", 64'(stray_count), 64'd3);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++) app_softreg_resp[j].valid = 1'b1;
            step();
        end
        clear_resp();
        step();
        chk("stray_saturate", 64'(stray_count), 64'hF);
        app_enable = '0;
        for (int i = 0; i < 17; i++) send(1'b1, 64'(i) << 3, 64'(i));
        repeat (4) step();
        chk("drop_saturate",  64'(drop_count), 64'hF);
        chk("sat_timeout",    64'(timeout_count), 64'h0);
        app_enable = '1;

        repeat (3) step();
        chk("end_app_q",  64'(app_q.size()), 64'h0);
        chk("end_resp_q", 64'(resp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
